imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU's instruction memory and drives its write side. It accepts a byte stream (valid/ready) carrying a word-count header followed by big-endian instruction words, packs bytes into 32-bit words, and writes them to consecutive word addresses. It holds the CPU in reset until the image is fully and validly loaded.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 59 +++++
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the boot-time instruction-memory loader:
//   loader state encoding and the stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HEADER,
        LOAD,
        CKSUM,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned HEADER_BYTES = 4;  // bytes in the big-endian word-count header
    localparam int unsigned WORD_BYTES   = 4;  // bytes per instruction word
    localparam int unsigned ADDR_STEP    = 4;  // byte-address increment per written word

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
//   Packs a big-endian byte stream into 32-bit words. The first byte of a
//   group lands in bits 31:24. word_out/word_valid are combinational so the
//   consumer sees the completed word in the same cycle as its last byte.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   clear      in   1   synchronous clear of counter and shift register
//   byte_in    in   8   incoming byte
//   byte_en    in   1   byte_in is accepted this cycle
//   word_out   out  32  packed word (valid when word_valid is high)
//   word_valid out  1   one-cycle pulse with the last byte of a group
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned BYTES = WORD_BYTES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic [31:0] word_out,
    output logic        word_valid
);

    localparam logic [1:0] LAST = 2'(BYTES - 1);

    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] shreg_q, shreg_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clear) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (byte_en) begin
            shreg_d = {shreg_q[23:0], byte_in};
            cnt_d   = (cnt_q == LAST) ? 2'd0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // The completed word includes the byte arriving this cycle.
    assign word_out   = {shreg_q[23:0], byte_in};
    assign word_valid = byte_en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader driving the write side of the instruction
//   memory. Accepts a byte stream: 4-byte big-endian word count N, then N
//   big-endian words, written to BASE_ADDR + 4*k. Holds the CPU in reset
//   until the image is completely and validly loaded.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- adds a trailing
//   checksum byte (XOR of all payload bytes) checked before DONE.
//
// Ports
//   clock             in   1   rising-edge clock
//   reset             in   1   synchronous active-high reset
//   byte_valid        in   1   source presents byte_data
//   byte_data         in   8   stream byte
//   byte_ready        out  1   loader accepts a byte (HEADER/LOAD/CKSUM)
//   mem_write_enabled out  1   registered one-cycle write strobe
//   mem_address       out  32  registered byte address of the write
//   mem_data          out  32  registered instruction word
//   cpu_reset         out  1   high in every state except DONE
//   load_done         out  1   sticky success flag
//   load_error        out  1   sticky reject flag
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_write_enabled,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned WCW        = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] MAX_N      = 32'(MAX_WORDS);
    localparam int unsigned PACK_BYTES = (HEADER_BYTES > WORD_BYTES) ? HEADER_BYTES : WORD_BYTES;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CKSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t           state_q,  state_d;
    logic [WCW-1:0]   wcnt_q,   wcnt_d;
    logic [WCW-1:0]   nwords_q, nwords_d;
    logic [31:0]      addr_q,   addr_d;
    logic             we_q,     we_d;
    logic [31:0]      maddr_q,  maddr_d;
    logic [31:0]      mdata_q,  mdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       cks_q,    cks_d;
`endif

    logic        accept;
    logic [31:0] word;
    logic        word_valid;

    assign byte_ready = (state_q == HEADER) || (state_q == LOAD) || (state_q == CKSUM);
    assign accept     = byte_valid && byte_ready;

    // Header and payload share one packer; it is idle-cleared once the
    // loader stops accepting bytes.
    byte_packer #(
        .BYTES (PACK_BYTES)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (!byte_ready),
        .byte_in    (byte_data),
        .byte_en    (accept),
        .word_out   (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        nwords_d = nwords_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cks_d    = cks_q;
`endif
        case (state_q)
            HEADER: begin
                wcnt_d = '0;
                addr_d = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                cks_d  = '0;
`endif
                if (word_valid) begin
                    if (word == 32'h0) begin
                        state_d = PAYLOAD_END;
                    end else if (word > MAX_N) begin
                        state_d = ERROR;
                    end else begin
                        nwords_d = word[WCW-1:0];
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    cks_d = cks_q ^ byte_data;
                end
`endif
                if (word_valid) begin
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    mdata_d = word;
                    addr_d  = addr_q + 32'(ADDR_STEP);
                    wcnt_d  = wcnt_q + WCW'(1);
                    if ((wcnt_q + WCW'(1)) == nwords_q) begin
                        state_d = PAYLOAD_END;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CKSUM: begin
                if (accept) begin
                    state_d = (byte_data == cks_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                // DONE and ERROR hold until reset.
            end
        endcase
    end

    // ---- state / output register stage ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= HEADER;
            wcnt_q   <= '0;
            nwords_q <= '0;
            addr_q   <= BASE_ADDR;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cks_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            nwords_q <= nwords_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cks_q    <= cks_d;
`endif
        end
    end

    assign mem_write_enabled = we_q;
    assign mem_address       = maddr_q;
    assign mem_data          = mdata_q;
    assign cpu_reset         = (state_q != DONE);
    assign load_done         = (state_q == DONE);
    assign load_error        = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed self-checking bench for imem_loader (BASE_ADDR = 0,
//   MAX_WORDS = 1024). Expected values are hand-computed constants.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_write_enabled;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int errors = 0;
    int checks = 0;
    int wr_total = 0;
    int base = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];

    always #5 clock = ~clock;

    imem_loader #(
        .BASE_ADDR (32'h0),
        .MAX_WORDS (1024)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .mem_write_enabled (mem_write_enabled),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .cpu_reset         (cpu_reset),
        .load_done         (load_done),
        .load_error        (load_error)
    );

    // Write monitor: samples shortly after each rising edge.
    always @(posedge clock) begin
        #2;
        if (mem_write_enabled === 1'b1) begin
            wr_addr[wr_total % 16] = mem_address;
            wr_data[wr_total % 16] = mem_data;
            wr_total++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reset for two cycles while presenting junk bytes that must be ignored.
    task automatic do_reset();
        @(negedge clock);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        reset      = 1'b1;
        repeat (2) @(negedge clock);
        reset      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Present one byte and return at the falling edge after its acceptance.
    task automatic send(input logic [7:0] b, input bit gaps);
        bit acc;
        acc = 1'b0;
        if (gaps) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = byte_ready;
            @(negedge clock);
        end
        if (!acc) check("byte_ready_timeout", {31'b0, byte_ready}, 32'h1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], gaps);
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        check("rst_ready", byte_ready, 1);
        check("rst_we", mem_write_enabled, 0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_data", mem_data, 32'h0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);

        // ---- N=2 image, byte_valid held high ----
        base = wr_total;
        send_word(32'd2, 1'b0);
        check("A_hdr_no_we", mem_write_enabled, 0);
        check("A_hdr_cpu_reset", cpu_reset, 1);
        send_word(32'h20080005, 1'b0);
        check("A_w0_we", mem_write_enabled, 1);
        check("A_w0_addr", mem_address, 32'h0);
        check("A_w0_data", mem_data, 32'h20080005);
        check("A_w0_cpu_reset", cpu_reset, 1);
        send(8'hAC, 1'b0);
        check("A_strobe_one_cycle", mem_write_enabled, 0);
        send(8'h08, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        check("A_w1_we", mem_write_enabled, 1);
        check("A_w1_addr", mem_address, 32'h4);
        check("A_w1_data", mem_data, 32'hAC080000);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("A_cks_wait_done", load_done, 0);
        check("A_cks_wait_cpu_reset", cpu_reset, 1);
        send(8'h89, 1'b0);
`endif
        check("A_done", load_done, 1);
        check("A_cpu_reset_low", cpu_reset, 0);
        check("A_ready_low", byte_ready, 0);
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("A_write_count", 32'(wr_total - base), 32'd2);
        check("A_done_sticky", load_done, 1);

        // ---- same image with random gaps ----
        do_reset();
        base = wr_total;
        send_word(32'd2, 1'b1);
        send_word(32'h20080005, 1'b1);
        send_word(32'hAC080000, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h89, 1'b1);
`endif
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("B_write_count", 32'(wr_total - base), 32'd2);
        check("B_w0_addr", wr_addr[base % 16], 32'h0);
        check("B_w0_data", wr_data[base % 16], 32'h20080005);
        check("B_w1_addr", wr_addr[(base + 1) % 16], 32'h4);
        check("B_w1_data", wr_data[(base + 1) % 16], 32'hAC080000);
        check("B_done", load_done, 1);

        // ---- oversize header N = MAX_WORDS + 1 ----
        do_reset();
        base = wr_total;
        send_word(32'd1025, 1'b0);
        check("C_error", load_error, 1);
        check("C_ready_low", byte_ready, 0);
        check("C_cpu_reset", cpu_reset, 1);
        check("C_no_done", load_done, 0);
        byte_data = 8'h5A;
        repeat (4) @(negedge clock);
        byte_valid = 1'b0;
        check("C_write_count", 32'(wr_total - base), 32'd0);
        check("C_error_sticky", load_error, 1);

        // ---- reset mid-load, then N=1 image ----
        do_reset();
        send_word(32'd2, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        do_reset();
        check("D_cpu_reset_after_rst", cpu_reset, 1);
        base = wr_total;
        send_word(32'd1, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h22, 1'b0);
`endif
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("D_write_count", 32'(wr_total - base), 32'd1);
        check("D_w0_addr", wr_addr[base % 16], 32'h0);
        check("D_w0_data", wr_data[base % 16], 32'hDEADBEEF);
        check("D_done", load_done, 1);

        // ---- N = 0 ----
        do_reset();
        base = wr_total;
        send_word(32'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("E_cks_wait", load_done, 0);
        send(8'h00, 1'b0);
`endif
        check("E_done", load_done, 1);
        check("E_cpu_reset_low", cpu_reset, 0);
        byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("E_write_count", 32'(wr_total - base), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- checksum match and mismatch ----
        do_reset();
        send_word(32'd1, 1'b0);
        send_word(32'h01020304, 1'b0);
        send(8'h04, 1'b0);
        byte_valid = 1'b0;
        check("F_cks_match_done", load_done, 1);
        do_reset();
        send_word(32'd1, 1'b0);
        send_word(32'h01020304, 1'b0);
        send(8'h05, 1'b0);
        byte_valid = 1'b0;
        check("F_cks_bad_error", load_error, 1);
        check("F_cks_bad_cpu_reset", cpu_reset, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
